// File: rtl/flappy_game_if.sv
// Event and status bundle between the FlappyBird game controller and the
// keypad / display / renderer side of the system.
interface flappy_game_if;
    logic       frame_tick;
    logic       key_ready;
    logic       collide;
    logic       pipe_pass;
    logic [1:0] state;
    logic [8:0] bird_y;
    logic [7:0] score;
    logic       scroll_en;
    logic       is_dead;

    // Environment side: produces events, consumes game status.
    modport master (
        output frame_tick, key_ready, collide, pipe_pass,
        input  state, bird_y, score, scroll_en, is_dead
    );

    // Controller side: consumes events, produces game status.
    modport slave (
        input  frame_tick, key_ready, collide, pipe_pass,
        output state, bird_y, score, scroll_en, is_dead
    );
endinterface

// File: rtl/flappy_game_ctrl.sv
// FlappyBird game-state controller: WAIT/FLY/DEAD state machine, bird
// vertical physics, flap capture, BCD scoring and the post-death restart hold.
// All status outputs come straight from registers.
module flappy_game_ctrl #(
    parameter int Y_INIT    = 240,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 464,
    parameter int GRAVITY   = 1,
    parameter int FLAP_V    = 8,
    parameter int V_MAX     = 8,
    parameter int DEAD_HOLD = 60
) (
    input  logic          clk,
    input  logic          rst,
    flappy_game_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_FLY  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam int HOLD_W = $clog2(DEAD_HOLD + 1);

    localparam logic        [8:0]  Y_INIT_V  = 9'(Y_INIT);
    localparam logic        [8:0]  Y_MIN_V   = 9'(Y_MIN);
    localparam logic        [8:0]  Y_MAX_V   = 9'(Y_MAX);
    localparam logic signed [10:0] Y_MIN_S   = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S   = 11'(Y_MAX);
    localparam logic signed [5:0]  FLAP_NEG  = 6'(-FLAP_V);
    localparam logic signed [6:0]  GRAV_S    = 7'(GRAVITY);
    localparam logic signed [6:0]  V_MAX_S   = 7'(V_MAX);
    localparam logic [HOLD_W-1:0]  HOLD_DONE = HOLD_W'(DEAD_HOLD);

    // Saturating two-digit packed-BCD increment (8'h99 stays 8'h99).
    function automatic logic [7:0] bcd_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'h99) begin
            result = 8'h99;
        end else if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

    state_t               state_r;
    logic [8:0]           bird_y_r;
    logic signed [5:0]    vel_r;
    logic [7:0]           score_r;
    logic                 flap_req_r;
    logic [HOLD_W-1:0]    hold_cnt_r;
    logic                 key_prev_r;
    logic                 scroll_en_r;
    logic                 is_dead_r;

    logic                 key_edge_s;
    logic signed [6:0]    vel_grav_s;
    logic signed [5:0]    vel_new_s;
    logic signed [10:0]   y_next_s;
    logic                 hit_ceil_s;
    logic                 hit_floor_s;
    logic                 die_s;

    // Key edge, next velocity, next position and the death condition for a FLY tick.
    always_comb begin
        key_edge_s  = bus.key_ready & ~key_prev_r;
        vel_grav_s  = $signed({vel_r[5], vel_r}) + GRAV_S;
        if (flap_req_r || key_edge_s) begin
            vel_new_s = FLAP_NEG;
        end else if (vel_grav_s > V_MAX_S) begin
            vel_new_s = V_MAX_S[5:0];
        end else begin
            vel_new_s = vel_grav_s[5:0];
        end
        y_next_s    = $signed({2'b00, bird_y_r}) + $signed({{5{vel_new_s[5]}}, vel_new_s});
        hit_ceil_s  = (y_next_s < Y_MIN_S);
        hit_floor_s = (y_next_s >= Y_MAX_S);
        die_s       = bus.frame_tick & ((hit_floor_s & ~hit_ceil_s) | bus.collide);
    end

    // Game state machine with all physics, score and hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_WAIT;
            bird_y_r    <= Y_INIT_V;
            vel_r       <= 6'sd0;
            score_r     <= 8'h00;
            flap_req_r  <= 1'b0;
            hold_cnt_r  <= '0;
            key_prev_r  <= 1'b1;
            scroll_en_r <= 1'b0;
            is_dead_r   <= 1'b0;
        end else begin
            key_prev_r <= bus.key_ready;
            case (state_r)
                ST_WAIT: begin
                    bird_y_r   <= Y_INIT_V;
                    flap_req_r <= 1'b0;
                    hold_cnt_r <= '0;
                    if (key_edge_s) begin
                        state_r     <= ST_FLY;
                        vel_r       <= FLAP_NEG;
                        score_r     <= 8'h00;
                        scroll_en_r <= 1'b1;
                        is_dead_r   <= 1'b0;
                    end else begin
                        vel_r       <= 6'sd0;
                        scroll_en_r <= 1'b0;
                        is_dead_r   <= 1'b0;
                    end
                end
                ST_FLY: begin
                    // A tick consumes any pending flap; otherwise edges collapse into one request.
                    if (bus.frame_tick) begin
                        flap_req_r <= 1'b0;
                        if (hit_ceil_s) begin
                            bird_y_r <= Y_MIN_V;
                            vel_r    <= 6'sd0;
                        end else if (hit_floor_s) begin
                            bird_y_r <= Y_MAX_V;
                            vel_r    <= vel_new_s;
                        end else begin
                            bird_y_r <= y_next_s[8:0];
                            vel_r    <= vel_new_s;
                        end
                    end else if (key_edge_s) begin
                        flap_req_r <= 1'b1;
                    end else begin
                        flap_req_r <= flap_req_r;
                    end
                    // Death outranks a coincident pipe pass.
                    if (die_s) begin
                        state_r     <= ST_DEAD;
                        scroll_en_r <= 1'b0;
                        is_dead_r   <= 1'b1;
                        hold_cnt_r  <= '0;
                    end else if (bus.pipe_pass) begin
                        score_r <= bcd_inc(score_r);
                    end else begin
                        score_r <= score_r;
                    end
                end
                ST_DEAD: begin
                    flap_req_r <= 1'b0;
                    if (bus.frame_tick && (hold_cnt_r != HOLD_DONE)) begin
                        hold_cnt_r <= hold_cnt_r + 1'b1;
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                    // Restart key is only honoured once the hold has fully elapsed.
                    if (key_edge_s && (hold_cnt_r == HOLD_DONE)) begin
                        state_r     <= ST_WAIT;
                        bird_y_r    <= Y_INIT_V;
                        vel_r       <= 6'sd0;
                        scroll_en_r <= 1'b0;
                        is_dead_r   <= 1'b0;
                    end else begin
                        scroll_en_r <= 1'b0;
                        is_dead_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_WAIT;
                    bird_y_r    <= Y_INIT_V;
                    vel_r       <= 6'sd0;
                    flap_req_r  <= 1'b0;
                    hold_cnt_r  <= '0;
                    scroll_en_r <= 1'b0;
                    is_dead_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state     = state_r;
    assign bus.bird_y    = bird_y_r;
    assign bus.score     = score_r;
    assign bus.scroll_en = scroll_en_r;
    assign bus.is_dead   = is_dead_r;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed scoreboard bench for flappy_game_ctrl.
module tb_flappy_game_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    flappy_game_if bus ();

    flappy_game_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: tag, observed-field selector and expected value.
    string tag_q[$];
    int    sel_q[$];
    int    exp_q[$];

    function automatic int observe(input int sel);
        case (sel)
            0:       return int'(bus.state);
            1:       return int'(bus.bird_y);
            2:       return int'(bus.score);
            3:       return int'(bus.scroll_en);
            4:       return int'(bus.is_dead);
            default: return -1;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input int val);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(val);
    endtask

    task automatic check_out();
        string t;
        int    s;
        int    e;
        int    o;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            o = observe(s);
            checks++;
            assert (o === e) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", t, o, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic key_edge();
        bus.key_ready = 1'b0;
        step();
        bus.key_ready = 1'b1;
        step();
    endtask

    task automatic pipe();
        bus.pipe_pass = 1'b1;
        step();
        bus.pipe_pass = 1'b0;
    endtask

    function automatic int to_bcd(input int n);
        return ((n / 10) << 4) | (n % 10);
    endfunction

    initial begin
        int n;
        int y;
        checks   = 0;
        failures = 0;
        bus.frame_tick = 1'b0;
        bus.key_ready  = 1'b1;
        bus.collide    = 1'b0;
        bus.pipe_pass  = 1'b0;

        // Reset with key held: no start afterwards.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        expect_val("rst_state", 0, 0);
        expect_val("rst_bird_y", 1, 240);
        expect_val("rst_score", 2, 8'h00);
        expect_val("rst_scroll", 3, 0);
        expect_val("rst_dead", 4, 0);
        check_out();
        step();
        step();
        expect_val("held_key_no_start", 0, 0);
        check_out();

        // Start and free-fall physics with three pipe passes on the way.
        key_edge();
        expect_val("start_state", 0, 1);
        expect_val("start_scroll", 3, 1);
        check_out();
        for (int k = 1; k <= 43; k++) begin
            if (k >= 3 && k <= 5) pipe();
            else step();
            tick();
            if (k == 1)  expect_val("phys_t1", 1, 233);
            if (k == 2)  expect_val("phys_t2", 1, 227);
            if (k == 15) expect_val("phys_t15", 1, 240);
            if (k == 16) expect_val("phys_t16", 1, 248);
            if (k == 42) expect_val("phys_t42_fly", 0, 1);
            if (k == 43) begin
                expect_val("ground_y", 1, 464);
                expect_val("ground_state", 0, 2);
                expect_val("ground_dead", 4, 1);
                expect_val("ground_scroll", 3, 0);
                expect_val("ground_score", 2, 8'h03);
            end
            check_out();
        end

        // Restart hold: edges ignored until 60 ticks elapsed in DEAD.
        for (int k = 0; k < 59; k++) begin
            step();
            tick();
        end
        key_edge();
        expect_val("hold59_state", 0, 2);
        check_out();
        tick();
        key_edge();
        expect_val("restart_state", 0, 0);
        expect_val("restart_y", 1, 240);
        expect_val("restart_score", 2, 8'h03);
        expect_val("restart_dead", 4, 0);
        check_out();
        key_edge();
        expect_val("replay_state", 0, 1);
        expect_val("replay_score", 2, 8'h00);
        check_out();

        // Ceiling: flap before every tick (odd k: edge in the tick cycle).
        for (int k = 1; k <= 32; k++) begin
            if (k == 5) begin
                key_edge();
            end
            bus.key_ready = 1'b0;
            step();
            if (k % 2 == 0) begin
                bus.key_ready = 1'b1;
                step();
                tick();
            end else begin
                bus.key_ready = 1'b1;
                tick();
            end
            y = 240 - 8 * k;
            if (y < 0) y = 0;
            expect_val("ceil_y", 1, y);
            expect_val("ceil_state", 0, 1);
            check_out();
        end

        // Score: BCD count with saturation at 99.
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            pipe();
            n = (n < 99) ? n + 1 : 99;
            expect_val("score_bcd", 2, to_bcd(n));
            check_out();
        end

        // Collide only on non-tick cycles (including edge cycles) never kills.
        for (int k = 0; k < 100; k++) begin
            bus.key_ready = 1'b0;
            bus.collide   = 1'b1;
            step();
            bus.key_ready = 1'b1;
            step();
            bus.collide = 1'b0;
            tick();
            expect_val("collide_gate_state", 0, 1);
            check_out();
        end
        expect_val("collide_gate_y", 1, 0);
        check_out();

        // Fall from the ceiling to row 300, then reset mid-flight with key held.
        for (int k = 0; k < 41; k++) begin
            step();
            tick();
        end
        expect_val("fall_y", 1, 300);
        expect_val("fall_state", 0, 1);
        check_out();
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_val("midrst_state", 0, 0);
        expect_val("midrst_y", 1, 240);
        expect_val("midrst_score", 2, 8'h00);
        expect_val("midrst_scroll", 3, 0);
        check_out();
        for (int k = 0; k < 4; k++) step();
        expect_val("midrst_held", 0, 0);
        check_out();
        key_edge();
        expect_val("midrst_repress", 0, 1);
        check_out();

        // Collide and pipe_pass in the same tick at score 05.
        for (int k = 0; k < 5; k++) pipe();
        expect_val("pre_collide_score", 2, 8'h05);
        check_out();
        bus.collide   = 1'b1;
        bus.pipe_pass = 1'b1;
        tick();
        bus.collide   = 1'b0;
        bus.pipe_pass = 1'b0;
        expect_val("collide_state", 0, 2);
        expect_val("collide_score", 2, 8'h05);
        expect_val("collide_y", 1, 233);
        expect_val("collide_dead", 4, 1);
        check_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flappy_game_ctrl.md
# flappy_game_ctrl

Game-state controller for FlappyBird. It replaces the ad-hoc combinational WAIT/FLY/DEAD latch in the top level with a registered state machine. It also owns bird vertical physics, flap-request capture, scoring and the post-death restart hold. It sits between the keypad/display blocks and the VGA renderer: it consumes frame ticks, key events and collision/pipe-pass events, and drives state, bird height, pipe scroll enable and a BCD score for the 7-segment device.

## Interface
Parameters:
- Y_INIT, 240: bird row on reset and on restart.
- Y_MIN, 0: ceiling row. Bird clamps here and does not die.
- Y_MAX, 464: ground row. Reaching it kills the bird.
- GRAVITY, 1: velocity increment per frame, rows.
- FLAP_V, 8: flap sets velocity to -FLAP_V.
- V_MAX, 8: maximum downward velocity.
- DEAD_HOLD, 60: frame ticks in DEAD before a restart key is accepted.

Ports:
- clk  in  1  system clock. One clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame.
- key_ready  in  1  keypad "any key down" level, already debounced.
- collide  in  1  bird/pipe overlap level from the display. Sampled only on frame_tick.
- pipe_pass  in  1  one-cycle pulse when the bird clears a pipe.
- state  out  2  0 = WAIT, 1 = FLY, 2 = DEAD. The value 3 never occurs.
- bird_y  out  9  bird top row, unsigned.
- score  out  8  two-digit packed BCD, range 8'h00..8'h99.
- scroll_en  out  1  high only in FLY. Pipes advance while high.
- is_dead  out  1  high only in DEAD.

## Operation
- Key edge detection: edge = key_ready & ~key_prev, where key_prev is a registered copy of key_ready. key_prev resets to 1, so a key held through reset produces no edge.
- Velocity: vel is a signed 6-bit register. Position arithmetic uses signed 11 bits: y_next = bird_y + vel_new.
- WAIT:
  - bird_y = Y_INIT and vel = 0. frame_tick is ignored.
  - On edge: go to FLY, vel <= -FLAP_V, score <= 0.
- FLY:
  - An edge sets flap_req. flap_req is cleared at the next frame_tick.
  - On frame_tick: vel_new = -FLAP_V if flap_req (or an edge in the same cycle), else min(vel+GRAVITY, V_MAX). Then compute y_next.
  - If y_next < Y_MIN: bird_y <= Y_MIN and vel <= 0. No death.
  - Else if y_next >= Y_MAX: bird_y <= Y_MAX and go to DEAD.
  - Else: bird_y <= y_next.
  - If collide is high on frame_tick: go to DEAD. bird_y still takes its updated value for that tick.
  - On pipe_pass: BCD increment. Low digit 9 wraps to 0 with a carry into the high digit. Score saturates at 8'h99.
  - If pipe_pass coincides with the cycle that transitions to DEAD, the increment is suppressed.
- DEAD:
  - bird_y, vel and score are frozen.
  - hold_cnt clears on entry and counts frame_ticks, saturating at DEAD_HOLD.
  - While hold_cnt < DEAD_HOLD, edges are ignored and not latched.
  - Once hold_cnt = DEAD_HOLD, an edge sends the block to WAIT: bird_y <= Y_INIT, vel <= 0, score retained.
- Reset: state = WAIT, bird_y = Y_INIT, vel = 0, score = 8'h00, flap_req = 0, hold_cnt = 0, key_prev = 1, scroll_en = 0, is_dead = 0. Reset overrides every in-progress operation in every state.

## Timing
- All outputs are registered. state, scroll_en and is_dead change on the clock edge after the qualifying input cycle (latency 1).
- bird_y updates on the clock edge after the frame_tick cycle.
- A flap edge in FLY takes effect at the next frame_tick. If the edge and frame_tick fall in the same cycle, it takes effect in that tick.
- Multiple edges between ticks collapse into a single flap.
- Priority within one cycle: rst > death (ground or collide) > pipe_pass > flap.
- collide outside frame_tick cycles has no effect.

## Test plan
- Start/physics: rst, then key_ready rises. Required: state = 1 one cycle later and vel = -8. With no further keys: bird_y = 233 after tick 1, 227 after tick 2, 240 after tick 15, 248 after tick 16. At tick 43 bird_y = 464, state = 2, is_dead = 1, scroll_en = 0.
- Ceiling: flap edge before every tick from Y_INIT. Required: bird_y = 232, 224, … down to 0, then stays at 0. state remains 1.
- Score: 99 pipe_pass pulses in FLY give score = 8'h99, and pulses 9→10 give 8'h09→8'h10. The 100th pulse leaves 8'h99. Separately, collide and pipe_pass in the same frame_tick cycle at score 8'h05 give state = 2 and score = 8'h05.
- Restart hold: in DEAD, a key edge after 59 ticks leaves state = 2. An edge after the 60th tick gives state = 0, bird_y = 240, score unchanged. The next edge gives state = 1 and score = 8'h00.
- Reset mid-flight: assert rst in FLY at bird_y = 300 with key_ready held high. Required: state = 0, bird_y = 240, score = 0, and no transition to FLY while the key stays held. Release and press again: state = 1.
- Collide gating: collide high only on non-tick cycles for 100 frames. Required: state stays 1.
